round_ctrl: RTL

//  Sequences one lottery round ahead of the cash digit-splitter. Loads the drawn numbers and reads the

---
 rtl/round_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/round_ctrl.sv
// ---------------------------------------------------------------------------
// round_ctrl
// Sequences one lottery round ahead of the cash digit-splitter. It loads the
// drawn numbers, reads the player's tickets one number at a time (rejecting
// illegal or repeated numbers), scores every completed ticket into a
// saturating payout sum, and finally pulses finish so the cash block can
// latch sum and V.
//
// Handshakes: a draw number is taken on a cycle where draw_valid && draw_ready,
// and a bet number on a cycle where n_valid && n_ready. The ready signals are
// pure state decodes and never depend on the valid inputs. A rejected number
// still completes its handshake; it raises err on the following cycle and is
// neither stored nor counted.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   start      in   1   begin a round (only looked at in IDLE)
//   draw_valid in   1   draw_num valid this cycle
//   draw_num   in   6   drawn number
//   draw_ready out  1   high in LOAD_DRAW
//   n_valid    in   1   N_in valid this cycle
//   N_in       in   6   player bet number
//   n_ready    out  1   high in READ_BET
//   bets_done  in   1   player has no more tickets
//   err        out  1   1-cycle pulse, number rejected
//   sum        out  10  accumulated payout, saturating at SAT_MAX
//   V          out  1   high while no ticket has been scored this round
//   finish     out  1   1-cycle pulse ending the round
//   busy       out  1   high in every state except IDLE
//   state_dbg  out  3   current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module round_ctrl #(
    parameter int N_BETS  = 5,
    parameter int MAX_NUM = 60,
    parameter int SAT_MAX = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       draw_valid,
    input  logic [5:0] draw_num,
    output logic       draw_ready,
    input  logic       n_valid,
    input  logic [5:0] N_in,
    output logic       n_ready,
    input  logic       bets_done,
    output logic       err,
    output logic [9:0] sum,
    output logic       V,
    output logic       finish,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_DRAW = 3'd1;
    localparam logic [2:0] READ_BET  = 3'd2;
    localparam logic [2:0] SCORE     = 3'd3;
    localparam logic [2:0] FINISH    = 3'd4;

    localparam logic [6:0] MAX_L    = 7'(MAX_NUM);
    localparam logic [2:0] LAST_IDX = 3'(N_BETS - 1);

    logic [2:0] state;
    logic [2:0] draw_cnt;
    logic [2:0] bet_cnt;
    logic [2:0] hits;
    logic [5:0] draw_reg [N_BETS];
    logic [5:0] bet_reg  [N_BETS];

    logic        draw_legal;
    logic        draw_dup;
    logic        bet_legal;
    logic        bet_dup;
    logic        bet_hit;
    logic [8:0]  prize;
    logic [10:0] sum_add;
    logic [9:0]  sum_sat;

    assign draw_ready = (state == LOAD_DRAW);
    assign n_ready    = (state == READ_BET);
    assign finish     = (state == FINISH);
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

    assign draw_legal = (draw_num != 6'd0) && ({1'b0, draw_num} <= MAX_L);
    assign bet_legal  = (N_in != 6'd0) && ({1'b0, N_in} <= MAX_L);

    // Only the entries already filled in this round/ticket take part in the
    // duplicate search. Every draw register is valid once READ_BET is reached,
    // so the hit search looks at all of them.
    always_comb begin
        draw_dup = 1'b0;
        bet_dup  = 1'b0;
        bet_hit  = 1'b0;
        for (int i = 0; i < N_BETS; i++) begin
            if ((3'(i) < draw_cnt) && (draw_reg[i] == draw_num)) draw_dup = 1'b1;
            if ((3'(i) < bet_cnt) && (bet_reg[i] == N_in))       bet_dup  = 1'b1;
            if (draw_reg[i] == N_in)                             bet_hit  = 1'b1;
        end
    end

    // Payout table relative to a full match. The N_BETS-3 tier only exists
    // when tickets have at least three numbers.
    always_comb begin
        prize = 9'd0;
        if (hits == 3'(N_BETS))
            prize = 9'd400;
        else if (hits == 3'(N_BETS - 1))
            prize = 9'd100;
        else if (hits == 3'(N_BETS - 2))
            prize = 9'd20;
        else if ((N_BETS >= 3) && (hits == 3'(N_BETS - 3)))
            prize = 9'd5;
    end

    // 999 + 400 fits in 11 bits, so the clamp sees the true sum.
    assign sum_add = {1'b0, sum} + {2'b00, prize};
    assign sum_sat = (sum_add > 11'(SAT_MAX)) ? 10'(SAT_MAX) : sum_add[9:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sum      <= 10'd0;
            V        <= 1'b0;
            err      <= 1'b0;
            draw_cnt <= 3'd0;
            bet_cnt  <= 3'd0;
            hits     <= 3'd0;
            for (int i = 0; i < N_BETS; i++) begin
                draw_reg[i] <= 6'd0;
                bet_reg[i]  <= 6'd0;
            end
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_DRAW;
                        sum      <= 10'd0;
                        V        <= 1'b1;
                        draw_cnt <= 3'd0;
                        bet_cnt  <= 3'd0;
                        hits     <= 3'd0;
                        for (int i = 0; i < N_BETS; i++) begin
                            draw_reg[i] <= 6'd0;
                            bet_reg[i]  <= 6'd0;
                        end
                    end
                end

                LOAD_DRAW: begin
                    if (draw_valid) begin
                        if (!draw_legal || draw_dup) begin
                            err <= 1'b1;
                        end else begin
                            draw_reg[draw_cnt] <= draw_num;
                            draw_cnt           <= draw_cnt + 3'd1;
                            if (draw_cnt == LAST_IDX) state <= READ_BET;
                        end
                    end
                end

                READ_BET: begin
                    // An empty ticket is the only point where the player may
                    // stop; this takes priority over a number offered in the
                    // same cycle, which is simply dropped.
                    if (bets_done && (bet_cnt == 3'd0)) begin
                        state <= FINISH;
                    end else if (n_valid) begin
                        if (!bet_legal || bet_dup) begin
                            err <= 1'b1;
                        end else begin
                            bet_reg[bet_cnt] <= N_in;
                            bet_cnt          <= bet_cnt + 3'd1;
                            hits             <= hits + {2'b00, bet_hit};
                            if (bet_cnt == LAST_IDX) state <= SCORE;
                        end
                    end
                end

                SCORE: begin
                    sum     <= sum_sat;
                    V       <= 1'b0;
                    hits    <= 3'd0;
                    bet_cnt <= 3'd0;
                    for (int i = 0; i < N_BETS; i++) bet_reg[i] <= 6'd0;
                    state   <= READ_BET;
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
